ac97_frame_tx: RTL and testbench

Outbound AC-link frame builder: serializes 256-bit AC'97 output frames onto the codec's SDATA_OUT pin, carrying stereo playback PCM (slots 3/4) and codec register writes (slots 1/2). It is the playback-direction counterpart to the capture path in `AC97Driver`, sitting between the FPGA sample/command producers and the `AUDSDO`/`AUDSYNC` pins. All logic runs on `fclk`; the codec's `BITCLK` is sampled as data and edge-detected.

---
 rtl/ac97_frame_tx.sv | 173 +++++++++++++++++
 tb/tb_ac97_frame_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ac97_frame_tx.sv
// AC'97 playback-direction frame builder: serializes 256-bit AC-link output frames
// carrying one stereo sample pair (slots 3/4) and an optional register write (slots 1/2).
module ac97_frame_tx (
  input  logic        fclk,
  input  logic        freset,
  input  logic        aBitClk,
  output logic        aSDO,
  output logic        aSync,
  input  logic [15:0] fAudLIn,
  input  logic [15:0] fAudRIn,
  input  logic        fSampleValid,
  output logic        fSampleReady,
  input  logic [6:0]  fCmdAddr,
  input  logic [15:0] fCmdData,
  input  logic        fCmdValid,
  output logic        fCmdReady,
  output logic        fFrameStart,
  output logic        fUnderrun
);

  logic [2:0]  bclk_q;
  logic        tick, frame_start, samp_xfer, cmd_xfer;
  logic [7:0]  cnt_q, cnt_d;

  logic        samp_full_q, samp_full_d, samp_rdy_q, samp_rdy_d;
  logic [15:0] samp_l_q, samp_l_d, samp_r_q, samp_r_d;
  logic        cmd_full_q, cmd_full_d, cmd_rdy_q, cmd_rdy_d;
  logic [6:0]  cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;

  logic        frm_samp_q, frm_samp_d, frm_cmd_q, frm_cmd_d;
  logic [15:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d, frm_data_q, frm_data_d;
  logic [6:0]  frm_addr_q, frm_addr_d;

  logic        sdo_q, sdo_d, sync_q, sync_d, start_q, start_d, und_q, und_d;
  logic [15:0] tag;
  logic [19:0] slot1, slot2, slot3, slot4;
  logic        frame_bit;

  // Bit clock synchronizer; left unreset so a reset never fabricates a rising edge.
  always_ff @(posedge fclk) begin
    bclk_q <= {bclk_q[1:0], aBitClk};
  end

  assign tick        = bclk_q[1] & ~bclk_q[2];
  assign frame_start = tick & (cnt_q == 8'd0);
  assign samp_xfer   = fSampleValid & samp_rdy_q;
  assign cmd_xfer    = fCmdValid & cmd_rdy_q;
  assign cnt_d       = tick ? (cnt_q + 8'd1) : cnt_q;

  // Select the bit for the current count from the latched frame contents.
  always_comb begin
    tag   = {1'b1, frm_cmd_q, frm_cmd_q, frm_samp_q, frm_samp_q, 11'd0};
    slot1 = frm_cmd_q  ? {1'b0, frm_addr_q, 12'd0} : 20'd0;
    slot2 = frm_cmd_q  ? {frm_data_q, 4'd0}        : 20'd0;
    slot3 = frm_samp_q ? {frm_l_q, 4'd0}           : 20'd0;
    slot4 = frm_samp_q ? {frm_r_q, 4'd0}           : 20'd0;
    if (cnt_q < 8'd16) begin
      frame_bit = tag[4'(8'd15 - cnt_q)];
    end else if (cnt_q < 8'd36) begin
      frame_bit = slot1[5'(8'd35 - cnt_q)];
    end else if (cnt_q < 8'd56) begin
      frame_bit = slot2[5'(8'd55 - cnt_q)];
    end else if (cnt_q < 8'd76) begin
      frame_bit = slot3[5'(8'd75 - cnt_q)];
    end else if (cnt_q < 8'd96) begin
      frame_bit = slot4[5'(8'd95 - cnt_q)];
    end else begin
      frame_bit = 1'b0;
    end
  end

  // Frame-start capture of the holding registers into the frame registers.
  always_comb begin
    if (frame_start) begin
      frm_samp_d = samp_full_q;
      frm_l_d    = samp_l_q;
      frm_r_d    = samp_r_q;
      frm_cmd_d  = cmd_full_q;
      frm_addr_d = cmd_addr_q;
      frm_data_d = cmd_data_q;
    end else begin
      frm_samp_d = frm_samp_q;
      frm_l_d    = frm_l_q;
      frm_r_d    = frm_r_q;
      frm_cmd_d  = frm_cmd_q;
      frm_addr_d = frm_addr_q;
      frm_data_d = frm_data_q;
    end
  end

  // Holding registers: a transfer on the frame-start cycle lands for the next frame.
  always_comb begin
    samp_full_d = samp_full_q & ~frame_start;
    cmd_full_d  = cmd_full_q & ~frame_start;
    if (samp_xfer) begin
      samp_full_d = 1'b1;
      samp_l_d    = fAudLIn;
      samp_r_d    = fAudRIn;
    end else begin
      samp_l_d    = samp_l_q;
      samp_r_d    = samp_r_q;
    end
    if (cmd_xfer) begin
      cmd_full_d = 1'b1;
      cmd_addr_d = fCmdAddr;
      cmd_data_d = fCmdData;
    end else begin
      cmd_addr_d = cmd_addr_q;
      cmd_data_d = cmd_data_q;
    end
    samp_rdy_d = ~samp_full_d;
    cmd_rdy_d  = ~cmd_full_d;
  end

  assign sdo_d   = tick ? frame_bit : sdo_q;
  assign sync_d  = tick ? (cnt_q < 8'd16) : sync_q;
  assign start_d = frame_start;
  assign und_d   = frame_start & ~samp_full_q;

  // State and registered outputs.
  always_ff @(posedge fclk) begin
    if (freset) begin
      cnt_q       <= 8'd0;
      samp_full_q <= 1'b0;
      samp_rdy_q  <= 1'b0;
      samp_l_q    <= 16'd0;
      samp_r_q    <= 16'd0;
      cmd_full_q  <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      cmd_addr_q  <= 7'd0;
      cmd_data_q  <= 16'd0;
      frm_samp_q  <= 1'b0;
      frm_l_q     <= 16'd0;
      frm_r_q     <= 16'd0;
      frm_cmd_q   <= 1'b0;
      frm_addr_q  <= 7'd0;
      frm_data_q  <= 16'd0;
      sdo_q       <= 1'b0;
      sync_q      <= 1'b0;
      start_q     <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      samp_full_q <= samp_full_d;
      samp_rdy_q  <= samp_rdy_d;
      samp_l_q    <= samp_l_d;
      samp_r_q    <= samp_r_d;
      cmd_full_q  <= cmd_full_d;
      cmd_rdy_q   <= cmd_rdy_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      frm_samp_q  <= frm_samp_d;
      frm_l_q     <= frm_l_d;
      frm_r_q     <= frm_r_d;
      frm_cmd_q   <= frm_cmd_d;
      frm_addr_q  <= frm_addr_d;
      frm_data_q  <= frm_data_d;
      sdo_q       <= sdo_d;
      sync_q      <= sync_d;
      start_q     <= start_d;
      und_q       <= und_d;
    end
  end

  assign aSDO         = sdo_q;
  assign aSync        = sync_q;
  assign fSampleReady = samp_rdy_q;
  assign fCmdReady    = cmd_rdy_q;
  assign fFrameStart  = start_q;
  assign fUnderrun    = und_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Scoreboard bench for ac97_frame_tx: a frame-level reference model pushes expected
// frames at each frame start; a codec-side monitor deserializes aSDO and compares.
module tb_ac97_frame_tx;

  logic        fclk = 1'b0, freset = 1'b1, aBitClk = 1'b0;
  logic        aSDO, aSync, fSampleReady, fCmdReady, fFrameStart, fUnderrun;
  logic [15:0] fAudLIn = 16'd0, fAudRIn = 16'd0, fCmdData = 16'd0;
  logic [6:0]  fCmdAddr = 7'd0;
  logic        fSampleValid = 1'b0, fCmdValid = 1'b0;

  ac97_frame_tx dut (
    .fclk(fclk), .freset(freset), .aBitClk(aBitClk), .aSDO(aSDO), .aSync(aSync),
    .fAudLIn(fAudLIn), .fAudRIn(fAudRIn), .fSampleValid(fSampleValid),
    .fSampleReady(fSampleReady), .fCmdAddr(fCmdAddr), .fCmdData(fCmdData),
    .fCmdValid(fCmdValid), .fCmdReady(fCmdReady), .fFrameStart(fFrameStart),
    .fUnderrun(fUnderrun)
  );

  always #5 fclk = ~fclk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model state
  int          ph = 7, m_cnt = 0, m_frames = 0, m_flushed = 0, frames_checked = 0;
  bit          m_sfull = 0, m_cfull = 0, m_rst_last = 1, m_start = 0, m_und = 0;
  bit          m_sxfer = 0, m_cxfer = 0, mon_abort = 0;
  logic [15:0] m_l, m_r, m_d;
  logic [6:0]  m_a;
  logic [255:0] exp_q[$];

  function automatic logic [255:0] build_frame(input bit s, input bit c, input logic [15:0] l,
                                               input logic [15:0] r, input logic [6:0] a,
                                               input logic [15:0] d);
    logic [15:0] tag;
    logic [19:0] s1, s2, s3, s4;
    tag = 16'h8000 | (c ? 16'h6000 : 16'h0000) | (s ? 16'h1800 : 16'h0000);
    s1  = c ? (20'(a) << 12) : 20'h0;
    s2  = c ? (20'(d) << 4)  : 20'h0;
    s3  = s ? (20'(l) << 4)  : 20'h0;
    s4  = s ? (20'(r) << 4)  : 20'h0;
    return {tag, s1, s2, s3, s4, 160'h0};
  endfunction

  // Bit clock (8 fclk per bit) and model; a bit is driven on the 3rd fclk edge after aBitClk rises.
  always @(posedge fclk) begin
    ph = (ph == 7) ? 0 : ph + 1;
    m_start = 0; m_und = 0; m_sxfer = 0; m_cxfer = 0;
    if (freset) begin
      m_sfull = 0; m_cfull = 0; m_cnt = 0; m_rst_last = 1; mon_abort = 1;
      m_flushed += exp_q.size();
      exp_q.delete();
    end else begin
      m_sxfer = fSampleValid && !m_sfull && !m_rst_last;
      m_cxfer = fCmdValid && !m_cfull && !m_rst_last;
      if (ph == 3) begin
        if (m_cnt == 0) begin
          m_start = 1;
          m_und = !m_sfull;
          exp_q.push_back(build_frame(m_sfull, m_cfull, m_l, m_r, m_a, m_d));
          m_frames++;
          m_sfull = 0; m_cfull = 0;
        end
        m_cnt = (m_cnt + 1) % 256;
      end
      if (m_sxfer) begin m_sfull = 1; m_l = fAudLIn; m_r = fAudRIn; end
      if (m_cxfer) begin m_cfull = 1; m_a = fCmdAddr; m_d = fCmdData; end
      m_rst_last = 0;
    end
    #2 aBitClk = (ph < 4);
  end

  // Per-cycle pulse, ready and reset-value checks.
  always @(negedge fclk) begin
    check("frame_start_pulse", 256'(fFrameStart), 256'(m_start));
    check("underrun_pulse", 256'(fUnderrun), 256'(m_und));
    check("sample_ready", 256'(fSampleReady), 256'(!m_sfull && !m_rst_last));
    check("cmd_ready", 256'(fCmdReady), 256'(!m_cfull && !m_rst_last));
    if (m_rst_last) begin
      check("reset_sdo", 256'(aSDO), 256'd0);
      check("reset_sync", 256'(aSync), 256'd0);
    end
  end

  // Codec-side monitor: samples on the falling bit clock edge, frames begin at aSync rise.
  logic [255:0] got_d, got_s, e;
  int  idx = 0;
  bit  coll = 0;
  always @(negedge aBitClk) begin
    if (mon_abort) begin coll = 0; mon_abort = 0; end
    if (!coll && aSync === 1'b1) begin coll = 1; idx = 0; end
    if (coll) begin
      got_d[255 - idx] = aSDO;
      got_s[255 - idx] = aSync;
      idx++;
      if (idx == 256) begin
        coll = 0;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL frame_unexpected: got frame %h expected none", got_d);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", got_d, e);
          check("frame_sync", got_s, {16'hFFFF, 240'h0});
          frames_checked++;
        end
      end
    end
  end

  task automatic offer(input bit do_s, input logic [15:0] l, input logic [15:0] r,
                       input bit do_c, input logic [6:0] a, input logic [15:0] d);
    int n = 0;
    fSampleValid = do_s; fAudLIn = l; fAudRIn = r;
    fCmdValid = do_c; fCmdAddr = a; fCmdData = d;
    while ((fSampleValid || fCmdValid) && n < 5000) begin
      @(negedge fclk);
      n++;
      if (m_sxfer) fSampleValid = 0;
      if (m_cxfer) fCmdValid = 0;
    end
    if (fSampleValid || fCmdValid) begin
      n_tests++; n_fail++;
      $display("FAIL offer_timeout: got no transfer in %0d cycles expected one", n);
      fSampleValid = 0; fCmdValid = 0;
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++; n_fail++;
    $display("FAIL %s: got timeout expected condition", nm);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge fclk);
    freset = 0;
    repeat (2400) @(negedge fclk);                       // idle: underrun frames
    offer(1, 16'h8001, 16'h7FFE, 0, 7'h00, 16'h0000);   // sample
    repeat (4200) @(negedge fclk);
    offer(0, 16'h0000, 16'h0000, 1, 7'h02, 16'h0808);   // command, not repeated
    repeat (4200) @(negedge fclk);
    n = 0;                                               // offer exactly on the frame-start cycle
    while (!(ph == 2 && m_cnt == 0 && !m_sfull) && n < 5000) begin @(negedge fclk); n++; end
    if (n >= 5000) timeout_fail("wait_frame_edge");
    fSampleValid = 1; fAudLIn = 16'h1234; fAudRIn = 16'hFEDC;
    @(negedge fclk);
    fSampleValid = 0;
    repeat (4200) @(negedge fclk);
    offer(1, 16'hA5A5, 16'h5A5A, 1, 7'h7F, 16'hC3C3);   // both in one frame
    offer(1, 16'h0F0F, 16'hF0F0, 0, 7'h00, 16'h0000);   // stalls until frame start
    repeat (4200) @(negedge fclk);
    n = 0;                                               // reset at bit 40 with a sample held
    while (!m_start && n < 5000) begin @(negedge fclk); n++; end
    if (n >= 5000) timeout_fail("wait_start");
    offer(1, 16'h4444, 16'h3333, 0, 7'h00, 16'h0000);
    n = 0;
    while (!(m_cnt == 40 && m_sfull) && n < 5000) begin @(negedge fclk); n++; end
    if (n >= 5000) timeout_fail("wait_bit40");
    freset = 1;
    @(negedge fclk);
    freset = 0;
    repeat (4200) @(negedge fclk);
    for (int i = 0; i < 16000; i++) begin              // randomized traffic
      @(negedge fclk);
      if (m_sxfer) fSampleValid = 0;
      if (m_cxfer) fCmdValid = 0;
      if (!fSampleValid && $urandom_range(0, 1499) == 0) begin
        fSampleValid = 1; fAudLIn = 16'($urandom); fAudRIn = 16'($urandom);
      end
      if (!fCmdValid && $urandom_range(0, 2999) == 0) begin
        fCmdValid = 1; fCmdAddr = 7'($urandom); fCmdData = 16'($urandom);
      end
    end
    @(negedge fclk);
    fSampleValid = 0; fCmdValid = 0;
    repeat (4200) @(negedge fclk);
    check("frames_seen", 256'(frames_checked), 256'(m_frames - m_flushed - exp_q.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
